// File: rtl/spi_pkg.sv
// Shared constants, frame-field helpers and FSM state type
// for the SPI register bank.
package spi_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned REG_RST_VAL = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    function automatic int frame_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a delay flop for edge detection.
// Exposes the synced level plus one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        dly_d  = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a small read/write register bank,
// with write strobes, read-back on cipo and a malformed-frame flag.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CW      = $clog2(FRAME_W + 1);
    localparam int A_LSB   = addr_lsb(DATA_W);
    localparam int D_LSB   = data_lsb();

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_copi (
        .clk(clk), .rst_n(rst_n), .d(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_ok;
    assign unused_ok = ^{ncs_lvl, sclk_lvl, copi_rise, copi_fall};

    state_e              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                ovf_q, ovf_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                frame_err_q, frame_err_d;

    logic                f_rw;
    logic [ADDR_W-1:0]   f_addr;
    logic [DATA_W-1:0]   f_data;
    logic                f_addr_ok;
    logic [DATA_W-1:0]   rd_val;

    assign f_rw      = rx_q[FRAME_W-1];
    assign f_addr    = rx_q[A_LSB +: ADDR_W];
    assign f_data    = rx_q[D_LSB +: DATA_W];
    assign f_addr_ok = {1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS);

    // Mid-frame the address sits in the low bits of the shifter.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_q[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ovf_d       = ovf_q;
        rw_d        = rw_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (ncs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    ovf_d     = 1'b0;
                    rw_d      = RW_WRITE;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                    if (bit_cnt_q == CW'(FRAME_W) && !ovf_q) begin
                        if (f_rw == RW_WRITE && f_addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (f_addr == ADDR_W'(i)) regs_d[i] = f_data;
                            end
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = f_addr;
                        end
                    end else if (bit_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (bit_cnt_q < CW'(FRAME_W)) begin
                        rx_d      = {rx_q[FRAME_W-2:0], copi_lvl};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == '0) rw_d = copi_lvl;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (sclk_fall && rw_q == RW_READ) begin
                    if (bit_cnt_q == CW'(1 + ADDR_W)) begin
                        tx_d = rd_val;
                    end else if (bit_cnt_q > CW'(1 + ADDR_W) &&
                                 bit_cnt_q < CW'(FRAME_W)) begin
                        tx_d = tx_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            ovf_q       <= 1'b0;
            rw_q        <= RW_WRITE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(REG_RST_VAL);
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ovf_q       <= ovf_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign cipo      = tx_q[DATA_W-1];
    assign cipo_oe   = (state_q == SHIFT) && (bit_cnt_q != '0) &&
                       (rw_q == RW_READ);
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: expected commits/errors and
// read data are queued as frames are driven, then matched on output.
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ncs;
    logic        sclk;
    logic        copi;
    logic        cipo;
    logic        cipo_oe;
    logic [39:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model [5];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 5; i++)
            chk($sformatf("reg%0d", i), regs_flat[i*8 +: 8], model[i]);
    endtask

    // Monitor: every strobe or error must match the next queued event.
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n && (wr_strobe || frame_err)) begin
            if (ev_q.size() == 0) begin
                chk("unexp_evt", {frame_err, wr_strobe}, 0);
            end else begin
                e = ev_q.pop_front();
                chk("evt_kind", {frame_err, wr_strobe},
                    e.wr ? 2'b01 : 2'b10);
                if (e.wr) begin
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", regs_flat[int'(e.addr)*8 +: 8], e.data);
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] frm, input int n,
                        input bit rd_chk, input bit close);
        logic [31:0] rx;
        logic [7:0]  exp;
        int          oe_bad;
        bit          exp_oe;
        rx     = '0;
        oe_bad = 0;
        exp_oe = (frm[n-1] == 1'b0);
        ncs    = 1'b0;
        #50;
        for (int i = n - 1; i >= 0; i--) begin
            copi = frm[i];
            #50;
            sclk = 1'b1;
            rx   = {rx[30:0], cipo};
            if (i < n - 1 && cipo_oe !== exp_oe) oe_bad++;
            #50;
            sclk = 1'b0;
        end
        if (!close) return;
        #50;
        ncs  = 1'b1;
        copi = 1'b0;
        #100;
        chk("oe_frame", oe_bad, 0);
        chk("oe_idle", cipo_oe, 0);
        if (rd_chk) begin
            exp = rd_q.pop_front();
            chk("rd_data", rx[7:0], exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        if (a < 5) begin
            model[a] = d;
            ev_q.push_back('{wr: 1'b1, addr: a, data: d});
        end
        xfer({16'd0, 1'b1, a, d}, 16, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [6:0] a);
        rd_q.push_back(a < 5 ? model[a] : 8'h00);
        xfer({16'd0, 1'b0, a, 8'h00}, 16, 1'b1, 1'b1);
    endtask

    task automatic bad(input logic [31:0] frm, input int n);
        ev_q.push_back('{wr: 1'b0, addr: 7'd0, data: 8'd0});
        xfer(frm, n, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        copi  = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (5) @(negedge clk);
        chk_regs();
        chk("rst_cipo", cipo, 0);
        chk("rst_oe", cipo_oe, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        wr(7'h04, 8'hA5);
        chk_regs();

        wr(7'h01, 8'h3C);
        rd(7'h01);
        chk_regs();

        wr(7'h05, 8'hFF);
        rd(7'h7F);
        rd(7'h04);
        chk_regs();

        bad(32'h84A, 12);
        bad(32'h1094B, 17);
        chk_regs();

        ncs = 1'b0;
        #100;
        ncs = 1'b1;
        #100;

        xfer(32'h104, 9, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        #50;
        ncs = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;
        chk_regs();
        wr(7'h02, 8'h66);
        chk_regs();

        wr(7'h00, 8'h11);
        wr(7'h03, 8'h22);
        chk_regs();

        repeat (10) @(negedge clk);
        chk("ev_left", ev_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
